mips_exec_mem: RTL and testbench

Single-cycle MIPS execute/memory slice: main + ALU-op decoder, a 32-bit ALU, the data memory, and the write-back result mux. It sits between the register file/sign extender and the register-file write port, and returns PC-control strobes to the program counter. All logic is combinational except data-memory writes.

---
 rtl/mips_pkg.sv | 35 +++
 rtl/mips_alu32.sv | 24 ++
 rtl/mips_exec_mem.sv | 81 ++++++++
 tb/tb_mips_exec_mem.sv | 114 +++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared opcode/funct/ALU constants and control-word type for the MIPS exec/mem slice
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_NONE = 3'b011;
  localparam logic [2:0] ALU_ANDN = 3'b100;
  localparam logic [2:0] ALU_ORN  = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  typedef struct packed {
    logic       reg_write;
    logic       reg_dest;
    logic       alu_src;
    logic       branch;
    logic       mem_write;
    logic       mem_to_reg;
    logic       jump;
    logic [1:0] aluop;
  } ctrl_t;
endpackage

// File: rtl/mips_alu32.sv
// mips_alu32: combinational ALU (op, a, b -> y, zero); add/sub wrap, slt is signed
module mips_alu32 import mips_pkg::*; #(
  parameter int DW = 32
) (
  input  logic [2:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y,
  output logic          zero
);
  always_comb begin
    case (op)
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_ADD:  y = a + b;
      ALU_ANDN: y = a & ~b;
      ALU_ORN:  y = a | ~b;
      ALU_SUB:  y = a - b;
      ALU_SLT:  y = {{(DW-1){1'b0}}, $signed(a) < $signed(b)};
      default:  y = '0;
    endcase
  end
  assign zero = y == '0;
endmodule

// File: rtl/mips_exec_mem.sv
// mips_exec_mem: single-cycle MIPS decode + ALU + data memory + write-back mux
// ports: clk/clr (async active-high, clears memory); opcode/funct decode into the
// datapath strobes and alu_control; rd1/rd2/sign_imm feed the ALU; alu_out addresses
// the word memory (wrapping, async read); result = mem_to_reg ? mem_rdata : alu_out.
// ADDI_EN: when defined, opcode 001000 decodes as addi; otherwise it is unrecognised.
module mips_exec_mem import mips_pkg::*; #(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [5:0]    opcode,
  input  logic [5:0]    funct,
  input  logic [DW-1:0] rd1,
  input  logic [DW-1:0] rd2,
  input  logic [DW-1:0] sign_imm,
  output logic [2:0]    alu_control,
  output logic          mem_to_reg,
  output logic          mem_write,
  output logic          alu_src,
  output logic          reg_dest,
  output logic          reg_write,
  output logic          pc_src,
  output logic          cjump,
  output logic [DW-1:0] alu_out,
  output logic          alu_zero,
  output logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] result
);
  ctrl_t c;
  logic [DW-1:0] mem [2**AW];
  always_comb begin
    c = '0;
    case (opcode)
      OP_RTYPE: c = 9'b1_1_0_0_0_0_0_10;
      OP_LW:    c = 9'b1_0_1_0_0_1_0_00;
      OP_SW:    c = 9'b0_0_1_0_1_0_0_00;
      OP_BEQ:   c = 9'b0_0_0_1_0_0_0_01;
      OP_J:     c = 9'b0_0_0_0_0_0_1_00;
`ifdef ADDI_EN
      OP_ADDI:  c = 9'b1_0_1_0_0_0_0_00;
`else
      OP_ADDI:  c = '0;
`endif
      default:  c = '0;
    endcase
  end
  always_comb begin
    alu_control = ALU_ADD;
    if (c.aluop == ALUOP_SUB)
      alu_control = ALU_SUB;
    else if (c.aluop == ALUOP_FUNCT)
      alu_control = funct == FN_SUB ? ALU_SUB :
                    funct == FN_AND ? ALU_AND :
                    funct == FN_OR  ? ALU_OR  :
                    funct == FN_SLT ? ALU_SLT : ALU_ADD;
  end
  assign reg_write  = c.reg_write;
  assign reg_dest   = c.reg_dest;
  assign alu_src    = c.alu_src;
  assign mem_write  = c.mem_write;
  assign mem_to_reg = c.mem_to_reg;
  assign cjump      = c.jump;
  assign pc_src     = c.branch & alu_zero;
  mips_alu32 #(.DW(DW)) u_alu (
    .op(alu_control),
    .a(rd1),
    .b(alu_src ? sign_imm : rd2),
    .y(alu_out),
    .zero(alu_zero)
  );
  // holding clr keeps every word at zero, so reads return 0 and writes are blocked
  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      mem <= '{default: '0};
    else if (mem_write)
      mem[alu_out[AW+1:2]] <= rd2;
  end
  assign mem_rdata = mem[alu_out[AW+1:2]];
  assign result = mem_to_reg ? mem_rdata : alu_out;
endmodule

// File: tb/tb_mips_exec_mem.sv
// tb_mips_exec_mem: directed self-checking bench for mips_exec_mem
module tb_mips_exec_mem;
  logic        clk = 0, clr = 0;
  logic [5:0]  opcode = 0, funct = 0;
  logic [31:0] rd1 = 0, rd2 = 0, sign_imm = 0;
  logic [2:0]  alu_control;
  logic        mem_to_reg, mem_write, alu_src, reg_dest, reg_write, pc_src, cjump, alu_zero;
  logic [31:0] alu_out, mem_rdata, result;
  logic [5:0]  strobes;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mips_exec_mem #(.AW(6), .DW(32)) dut (
    .clk(clk), .clr(clr), .opcode(opcode), .funct(funct), .rd1(rd1), .rd2(rd2),
    .sign_imm(sign_imm), .alu_control(alu_control), .mem_to_reg(mem_to_reg),
    .mem_write(mem_write), .alu_src(alu_src), .reg_dest(reg_dest), .reg_write(reg_write),
    .pc_src(pc_src), .cjump(cjump), .alu_out(alu_out), .alu_zero(alu_zero),
    .mem_rdata(mem_rdata), .result(result)
  );
  // {reg_write, reg_dest, alu_src, mem_write, mem_to_reg, cjump}
  assign strobes = {reg_write, reg_dest, alu_src, mem_write, mem_to_reg, cjump};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    @(negedge clk);
    opcode = op;
    funct = fn;
    rd1 = a;
    rd2 = b;
    sign_imm = imm;
    #1;
  endtask
  initial begin
    #2 clr = 1;
    #1 chk("reset_rdata", mem_rdata, 0);
    @(negedge clk) clr = 0;
    drive(6'b000000, 6'b100000, 5, 7, 0);
    chk("add_ctl", alu_control, 3'b010);
    chk("add_out", alu_out, 12);
    chk("add_strobes", strobes, 6'b110000);
    chk("add_result", result, 12);
    drive(6'b000000, 6'b100010, 5, 7, 0);
    chk("sub_out", alu_out, 32'hFFFFFFFE);
    drive(6'b000000, 6'b100100, 32'hF0F0_00FF, 32'h0FF0_0F0F, 0);
    chk("and_out", alu_out, 32'h00F0_000F);
    drive(6'b000000, 6'b100101, 32'hF0F0_00FF, 32'h0FF0_0F0F, 0);
    chk("or_out", alu_out, 32'hFFF0_0FFF);
    drive(6'b000000, 6'b111111, 2, 3, 0);
    chk("badfn_ctl", alu_control, 3'b010);
    drive(6'b000000, 6'b101010, 32'hFFFFFFFF, 1, 0);
    chk("slt_ctl", alu_control, 3'b111);
    chk("slt_neg", alu_out, 1);
    drive(6'b000000, 6'b101010, 1, 32'hFFFFFFFF, 0);
    chk("slt_swap", alu_out, 0);
    chk("slt_zero", alu_zero, 1);
    drive(6'b101011, 0, 0, 32'hDEADBEEF, 8);
    chk("sw_strobes", strobes, 6'b001100);
    chk("sw_addr", alu_out, 8);
    chk("sw_pre", mem_rdata, 0);
    @(posedge clk) #1;
    chk("sw_post", mem_rdata, 32'hDEADBEEF);
    drive(6'b100011, 0, 0, 0, 8);
    chk("lw_strobes", strobes, 6'b101010);
    chk("lw_rdata", mem_rdata, 32'hDEADBEEF);
    chk("lw_result", result, 32'hDEADBEEF);
    drive(6'b100011, 0, 0, 0, 32'h108);
    chk("lw_wrap", result, 32'hDEADBEEF);
    drive(6'b100011, 0, 4, 0, 0);
    chk("lw_word1", result, 0);
    drive(6'b101011, 0, 4, 32'h12345678, 4);
    chk("sw_old", mem_rdata, 32'hDEADBEEF);
    @(posedge clk) #1;
    chk("sw_new", mem_rdata, 32'h12345678);
    drive(6'b000100, 0, 3, 3, 0);
    chk("beq_ctl", alu_control, 3'b110);
    chk("beq_zero", alu_zero, 1);
    chk("beq_taken", pc_src, 1);
    chk("beq_strobes", strobes, 6'b000000);
    drive(6'b000100, 0, 3, 4, 0);
    chk("beq_not", pc_src, 0);
    drive(6'b100011, 0, 0, 0, 8);
    chk("pre_clr", mem_rdata, 32'h12345678);
    clr = 1;
    #1 chk("clr_mid", mem_rdata, 0);
    opcode = 6'b101011;
    rd2 = 32'hAAAA5555;
    @(posedge clk) #1;
    chk("clr_blocks", mem_rdata, 0);
    @(negedge clk) clr = 0;
    #1 chk("clr_release", mem_rdata, 0);
    @(posedge clk) #1;
    chk("first_write", mem_rdata, 32'hAAAA5555);
    drive(6'b000010, 0, 0, 0, 0);
    chk("j_strobes", strobes, 6'b000001);
    chk("j_pcsrc", pc_src, 0);
    drive(6'b111111, 0, 0, 0, 0);
    chk("ill_strobes", strobes, 6'b000000);
    chk("ill_ctl", alu_control, 3'b010);
    drive(6'b001000, 0, 10, 0, 32'hFFFFFFFF);
`ifdef ADDI_EN
    chk("addi_strobes", strobes, 6'b101000);
    chk("addi_out", alu_out, 9);
`else
    chk("addi_strobes", strobes, 6'b000000);
    chk("addi_ctl", alu_control, 3'b010);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
